wave_mixer: RTL and testbench
=============================

Name: wave_mixer

Overview:
- Sequential successor to the combinational channel adder.
- Mixes NUM unsigned N-bit oscillator channels into one OUT_W-bit audio sample. Each channel has its own volume and enable bit.
- Work is time-multiplexed: one multiply-accumulate per clock, triggered by a sample-rate tick.
- Sits between the per-channel oscillators and the audio DAC/PWM stage. Output is registered, saturating, and flagged valid once per sample.

Parameters:
- NUM, 4, number of channels (>=1)
- N, 4, bits per channel sample (unsigned)
- VOL_W, 4, bits per channel volume (unsigned; 0 = mute, max = full-scale gain)
- OUT_W, 12, audio output width
- SHIFT, 0, right shift applied to the accumulated sum before saturation

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- sample_tick  input  1  one-cycle pulse requesting a new mixed sample
- channels  input  NUM*N  channel i at [i*N +: N]
- volumes  input  NUM*VOL_W  volume i at [i*VOL_W +: VOL_W]
- enables  input  NUM  bit i high = channel i included in mix
- audio  output  OUT_W  registered mixed sample
- audio_valid  output  1  one-cycle pulse when audio updates
- busy  output  1  high while a mix is in progress (states ACC, DONE)
- clip  output  1  registered with audio; high if that sample saturated
- overrun  output  1  one-cycle pulse when sample_tick arrives while busy

Behaviour:
- Reset (rst_n low, asynchronous): audio=0, audio_valid=0, clip=0, overrun=0, busy=0, state=IDLE, accumulator=0, index=0, snapshot registers=0.
- Accumulator width: ACC_W = N+VOL_W+clog2(NUM) (min 1 extra bit). It never overflows internally.
- FSM states are IDLE, ACC, DONE.
- IDLE:
  - On an edge with sample_tick=1: snapshot channels, volumes and enables into internal registers; acc<=0; index<=0; go to ACC.
  - Inputs may change freely after the snapshot edge.
- ACC:
  - Each edge: acc <= acc + (snap_en[index] ? snap_ch[index]*snap_vol[index] : 0); index++.
  - After the edge that processes index NUM-1, go to DONE. This takes exactly NUM edges in ACC.
- DONE:
  - Next edge: s = acc >> SHIFT.
  - If s > 2^OUT_W-1: audio <= 2^OUT_W-1 and clip <= 1. Otherwise audio <= s[OUT_W-1:0] and clip <= 0.
  - audio_valid <= 1 for exactly one cycle; go to IDLE.
- Latency: tick sampled at edge E0 -> audio/audio_valid/clip update at edge E0+NUM+1.
  - A new tick is accepted in the IDLE cycle in which audio_valid is high, giving a back-to-back period of NUM+2 cycles.
- busy = (state != IDLE). It is registered alongside state, so it is high from E0+1 through E0+NUM+1 exclusive.
- A sample_tick seen at an edge while in ACC or DONE:
  - The tick is ignored; the in-flight mix is unaffected.
  - overrun pulses high for one cycle.
- audio and clip hold their value between updates and change only at the DONE edge.
- Zero volume or a disabled channel contributes 0. A channel value of 0 contributes 0 regardless of volume.
- Reset asserted mid-ACC: the mix is aborted immediately and all outputs return to reset values. No audio_valid is produced for the aborted mix.
- sample_tick held high continuously: one mix every NUM+2 cycles. Overrun pulses on every busy cycle.

Test Plan:
1. Defaults, enables=1111, volumes all 1, channels {8,4,2,1} (ch3..ch0), one tick -> audio_valid exactly 5 cycles after the tick edge, audio=15, clip=0, busy high 5 cycles.
2. All channels 15, all volumes 15, enables=1111 -> audio=900, clip=0. Then enables=0101 with the same values -> audio=450.
3. OUT_W=8, all channels 15, all volumes 15 -> audio=255, clip=1. Next tick with all volumes 1 -> audio=60, clip=0.
4. Tick; change channels to 0 the cycle after the tick; second tick 2 cycles later -> audio reflects the snapshot (e.g. 15 per case 1); overrun pulses once; only one audio_valid.
5. Tick, assert rst_n low for 1 cycle during ACC -> audio=0, busy=0, no audio_valid. Fresh tick after release -> correct sum.
6. SHIFT=2 with case-2 values -> audio=225. sample_tick held high for 20 cycles -> audio_valid every 6 cycles.

Source files
------------

// File: rtl/wave_mixer.sv
// Time-multiplexed audio mixer: one multiply-accumulate per clock over NUM snapshotted
// channels, then a shift and saturation into a registered OUT_W-bit sample.
module wave_mixer #(
    parameter int NUM   = 4,
    parameter int N     = 4,
    parameter int VOL_W = 4,
    parameter int OUT_W = 12,
    parameter int SHIFT = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sample_tick,
    input  logic [NUM*N-1:0]     channels,
    input  logic [NUM*VOL_W-1:0] volumes,
    input  logic [NUM-1:0]       enables,
    output logic [OUT_W-1:0]     audio,
    output logic                 audio_valid,
    output logic                 busy,
    output logic                 clip,
    output logic                 overrun
);

    localparam int LOG_NUM = (NUM > 1) ? $clog2(NUM) : 1;
    localparam int ACC_W   = N + VOL_W + LOG_NUM;
    localparam int IDX_W   = LOG_NUM;
    localparam int CMP_W   = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t state;
    state_t state_next;

    logic [N-1:0]     snap_ch  [NUM];
    logic [VOL_W-1:0] snap_vol [NUM];
    logic [NUM-1:0]   snap_en;
    logic [ACC_W-1:0] acc;
    logic [IDX_W-1:0] idx;
    logic             last;
    logic [ACC_W-1:0] term;
    logic [OUT_W:0]   sat_res;

    // Compare in a width wide enough for both the shifted sum and the output ceiling,
    // so the result is correct whichever of ACC_W and OUT_W is larger.
    function automatic logic [OUT_W:0] saturate(input logic [ACC_W-1:0] a);
        logic [CMP_W-1:0] s;
        logic [CMP_W-1:0] lim;
        s   = CMP_W'(a >> SHIFT);
        lim = CMP_W'({OUT_W{1'b1}});
        if (s > lim) saturate = {1'b1, {OUT_W{1'b1}}};
        else         saturate = {1'b0, s[OUT_W-1:0]};
    endfunction

    assign last    = (idx == IDX_W'(NUM - 1));
    assign sat_res = saturate(acc);

    always_comb begin
        term = '0;
        if (snap_en[idx]) term = ACC_W'(snap_ch[idx]) * ACC_W'(snap_vol[idx]);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (sample_tick) state_next = ACC;
            ACC:     if (last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Control: busy is registered from the next state so it tracks state exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            overrun     <= 1'b0;
            audio_valid <= 1'b0;
        end else begin
            state       <= state_next;
            busy        <= (state_next != IDLE);
            overrun     <= sample_tick && (state != IDLE);
            audio_valid <= (state == DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM; i++) begin
                snap_ch[i]  <= '0;
                snap_vol[i] <= '0;
            end
            snap_en <= '0;
            acc     <= '0;
            idx     <= '0;
            audio   <= '0;
            clip    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (sample_tick) begin
                        for (int i = 0; i < NUM; i++) begin
                            snap_ch[i]  <= channels[i*N +: N];
                            snap_vol[i] <= volumes[i*VOL_W +: VOL_W];
                        end
                        snap_en <= enables;
                        acc     <= '0;
                        idx     <= '0;
                    end
                end
                ACC: begin
                    acc <= acc + term;
                    idx <= idx + 1'b1;
                end
                DONE: begin
                    audio <= sat_res[OUT_W-1:0];
                    clip  <= sat_res[OUT_W];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wave_mixer.sv
// Directed bench for wave_mixer: three instances (default, OUT_W=8, SHIFT=2) share stimulus.
module tb_wave_mixer;

    logic        clk;
    logic        rst_n;
    logic        sample_tick;
    logic [15:0] channels;
    logic [15:0] volumes;
    logic [3:0]  enables;

    logic [11:0] audio_a;
    logic        valid_a, busy_a, clip_a, overrun_a;
    logic [7:0]  audio_b;
    logic        valid_b, busy_b, clip_b, overrun_b;
    logic [11:0] audio_c;
    logic        valid_c, busy_c, clip_c, overrun_c;

    int checks;
    int failures;

    wave_mixer dut_a (
        .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .channels(channels),
        .volumes(volumes), .enables(enables), .audio(audio_a), .audio_valid(valid_a),
        .busy(busy_a), .clip(clip_a), .overrun(overrun_a)
    );

    wave_mixer #(.OUT_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .channels(channels),
        .volumes(volumes), .enables(enables), .audio(audio_b), .audio_valid(valid_b),
        .busy(busy_b), .clip(clip_b), .overrun(overrun_b)
    );

    wave_mixer #(.SHIFT(2)) dut_c (
        .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .channels(channels),
        .volumes(volumes), .enables(enables), .audio(audio_c), .audio_valid(valid_c),
        .busy(busy_c), .clip(clip_c), .overrun(overrun_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one tick, then wait (bounded) for audio_valid; cyc counts edges after the tick edge.
    task automatic run_mix(output int cyc, output int busy_cnt);
        @(negedge clk);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        cyc      = 0;
        busy_cnt = busy_a ? 1 : 0;
        while (!valid_a && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (busy_a) busy_cnt++;
        end
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        sample_tick = 1'b0;
        channels    = 16'h8421;
        volumes     = 16'h1111;
        enables     = 4'b1111;
        repeat (3) @(negedge clk);
        checks++;
        if ({audio_a, valid_a, busy_a, clip_a, overrun_a} !== 16'h0) begin
            failures++;
            $display("FAIL reset_outputs: got audio=%0d valid=%b busy=%b clip=%b overrun=%b, want all 0",
                     audio_a, valid_a, busy_a, clip_a, overrun_a);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int cyc, bcnt;
        channels = 16'h8421;
        volumes  = 16'h1111;
        enables  = 4'b1111;
        run_mix(cyc, bcnt);
        checks++;
        if (cyc !== 5) begin
            failures++;
            $display("FAIL basic_latency: got %0d cycles, want 5", cyc);
        end
        checks++;
        if (audio_a !== 12'd15 || clip_a !== 1'b0) begin
            failures++;
            $display("FAIL basic_audio: got audio=%0d clip=%b, want 15/0", audio_a, clip_a);
        end
        checks++;
        if (bcnt !== 5) begin
            failures++;
            $display("FAIL basic_busy: got %0d busy cycles, want 5", bcnt);
        end
        @(negedge clk);
        checks++;
        if (valid_a !== 1'b0) begin
            failures++;
            $display("FAIL basic_valid_pulse: valid=%b one cycle later, want 0", valid_a);
        end
    endtask

    task automatic test_mix_and_clip();
        int cyc, bcnt;
        channels = 16'hFFFF;
        volumes  = 16'hFFFF;
        enables  = 4'b1111;
        run_mix(cyc, bcnt);
        checks++;
        if (audio_a !== 12'd900 || clip_a !== 1'b0) begin
            failures++;
            $display("FAIL full_scale: got audio=%0d clip=%b, want 900/0", audio_a, clip_a);
        end
        checks++;
        if (audio_b !== 8'd255 || clip_b !== 1'b1) begin
            failures++;
            $display("FAIL sat_out8: got audio=%0d clip=%b, want 255/1", audio_b, clip_b);
        end
        checks++;
        if (audio_c !== 12'd225) begin
            failures++;
            $display("FAIL shift2_full: got audio=%0d, want 225", audio_c);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (audio_a !== 12'd900 || clip_b !== 1'b1) begin
            failures++;
            $display("FAIL hold: got audio=%0d clip_b=%b, want 900/1", audio_a, clip_b);
        end
        enables = 4'b0101;
        run_mix(cyc, bcnt);
        checks++;
        if (audio_a !== 12'd450) begin
            failures++;
            $display("FAIL enables_0101: got audio=%0d, want 450", audio_a);
        end
        checks++;
        if (audio_c !== 12'd112) begin
            failures++;
            $display("FAIL shift2_half: got audio=%0d, want 112", audio_c);
        end
        enables = 4'b1111;
        volumes = 16'h1111;
        run_mix(cyc, bcnt);
        checks++;
        if (audio_b !== 8'd60 || clip_b !== 1'b0) begin
            failures++;
            $display("FAIL unsat_out8: got audio=%0d clip=%b, want 60/0", audio_b, clip_b);
        end
        volumes  = 16'h0F0F;
        channels = 16'hF0FF;
        run_mix(cyc, bcnt);
        checks++;
        if (audio_a !== 12'd225) begin
            failures++;
            $display("FAIL zero_terms: got audio=%0d, want 225", audio_a);
        end
    endtask

    task automatic test_snapshot_overrun();
        int ov, vcnt;
        logic [11:0] aud;
        channels = 16'h8421;
        volumes  = 16'h1111;
        enables  = 4'b1111;
        ov   = 0;
        vcnt = 0;
        aud  = 12'hFFF;
        @(negedge clk);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        channels    = 16'h0000;
        @(negedge clk);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (overrun_a) ov++;
            if (valid_a) begin
                vcnt++;
                aud = audio_a;
            end
            @(negedge clk);
        end
        checks++;
        if (aud !== 12'd15) begin
            failures++;
            $display("FAIL snapshot_audio: got %0d, want 15", aud);
        end
        checks++;
        if (ov !== 1) begin
            failures++;
            $display("FAIL overrun_count: got %0d, want 1", ov);
        end
        checks++;
        if (vcnt !== 1) begin
            failures++;
            $display("FAIL snapshot_valid_count: got %0d, want 1", vcnt);
        end
        channels = 16'h8421;
    endtask

    task automatic test_reset_mid();
        int cyc, bcnt, vcnt;
        channels = 16'h4444;
        volumes  = 16'h1111;
        enables  = 4'b1111;
        run_mix(cyc, bcnt);
        checks++;
        if (audio_a !== 12'd16) begin
            failures++;
            $display("FAIL premix: got %0d, want 16", audio_a);
        end
        channels = 16'h8421;
        @(negedge clk);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (audio_a !== 12'd0 || busy_a !== 1'b0 || valid_a !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset: got audio=%0d busy=%b valid=%b, want 0/0/0", audio_a, busy_a, valid_a);
        end
        @(negedge clk);
        rst_n = 1'b1;
        vcnt  = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (valid_a) vcnt++;
        end
        checks++;
        if (vcnt !== 0 || audio_a !== 12'd0) begin
            failures++;
            $display("FAIL aborted_mix: got %0d valids audio=%0d, want 0/0", vcnt, audio_a);
        end
        run_mix(cyc, bcnt);
        checks++;
        if (cyc !== 5 || audio_a !== 12'd15) begin
            failures++;
            $display("FAIL post_reset_mix: got cyc=%0d audio=%0d, want 5/15", cyc, audio_a);
        end
    endtask

    task automatic test_back_to_back();
        int vcnt, ov, first, lastv;
        channels = 16'hFFFF;
        volumes  = 16'hFFFF;
        enables  = 4'b1111;
        vcnt  = 0;
        ov    = 0;
        first = -1;
        lastv = -1;
        @(negedge clk);
        sample_tick = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (valid_c) begin
                vcnt++;
                if (first < 0) first = i;
                lastv = i;
            end
            if (overrun_c) ov++;
        end
        sample_tick = 1'b0;
        checks++;
        if (vcnt !== 3 || first !== 5 || lastv !== 17) begin
            failures++;
            $display("FAIL held_tick_valids: got count=%0d first=%0d last=%0d, want 3/5/17", vcnt, first, lastv);
        end
        checks++;
        if (ov !== 16) begin
            failures++;
            $display("FAIL held_tick_overrun: got %0d, want 16", ov);
        end
        checks++;
        if (audio_c !== 12'd225) begin
            failures++;
            $display("FAIL held_tick_audio: got %0d, want 225", audio_c);
        end
        repeat (10) @(negedge clk);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_basic();
        test_mix_and_clip();
        test_snapshot_overrun();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
